// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes, FSM states and flag bit positions shared by the seq_alu slice.
package seq_alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_HOLD = 2'd2
  } state_e;
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
endpackage

// File: rtl/seq_alu_div.sv
// seq_alu_div: iterative restoring divider, one quotient bit per cycle, MSB first.
module seq_alu_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH:0] sh, diff;
  assign sh = {rem, quo[WIDTH-1]};
  assign diff = sh - {1'b0, dvs};
  // quotient/remainder present the result of the iteration in progress, so the
  // caller can capture the final values on the same edge that completes them
  assign quotient = {quo[WIDTH-2:0], !diff[WIDTH]};
  assign remainder = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign done = cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (start) begin
      cnt <= CW'(WIDTH);
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      rem <= remainder;
      quo <= quotient;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered 8-op ALU with valid/ready handshakes and multi-cycle divide;
// defining SEQ_ALU_FLAGS_EN adds registered {ovf, carry, zero} flags.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             err,
  output logic [2:0]       flags
);
  import seq_alu_pkg::*;
  state_e state, state_nxt;
  op_e opc;
  logic [WIDTH:0] sum, dif;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] alu_lo, alu_hi, q, r, nxt_lo, nxt_hi;
  logic alu_err, nxt_err, accept, div_go, div_done, load;
  assign opc = op_e'(op);
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
  assign in_ready = !rst && (state == S_IDLE || (state == S_HOLD && out_ready));
  assign out_valid = state == S_HOLD;
  assign accept = in_valid && in_ready;
  assign div_go = accept && opc == OP_DIV && b != '0;
  seq_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_go),
    .dividend(a),
    .divisor(b),
    .done(div_done),
    .quotient(q),
    .remainder(r)
  );
  always_comb begin
    alu_lo = '0;
    alu_hi = '0;
    alu_err = 1'b0;
    case (opc)
      OP_ADD: begin
        alu_lo = sum[WIDTH-1:0];
        alu_hi[0] = sum[WIDTH];
      end
      OP_SUB: begin
        alu_lo = dif[WIDTH-1:0];
        alu_hi[0] = dif[WIDTH];
      end
      OP_MUL: begin
        alu_lo = prod[WIDTH-1:0];
        alu_hi = prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        alu_lo = '1;
        alu_hi = a;
        alu_err = 1'b1;
      end
      OP_AND: alu_lo = a & b;
      OP_OR:  alu_lo = a | b;
      OP_XOR: alu_lo = a ^ b;
      default: alu_lo = ~a;
    endcase
  end
  assign load = (accept && !div_go) || (state == S_DIV && div_done);
  assign nxt_lo = state == S_DIV ? q : alu_lo;
  assign nxt_hi = state == S_DIV ? r : alu_hi;
  assign nxt_err = state != S_DIV && alu_err;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HOLD: state_nxt = accept ? (div_go ? S_DIV : S_HOLD) :
                                  (state == S_HOLD && out_ready) ? S_IDLE : state;
      S_DIV: state_nxt = div_done ? S_HOLD : S_DIV;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      result <= '0;
      result_hi <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        result <= nxt_lo;
        result_hi <= nxt_hi;
        err <= nxt_err;
      end
    end
  end
`ifdef SEQ_ALU_FLAGS_EN
  logic [2:0] flg_nxt;
  always_comb begin
    flg_nxt = '0;
    flg_nxt[FLAG_ZERO] = nxt_lo == '0;
    if (state != S_DIV) begin
      flg_nxt[FLAG_CARRY] = opc == OP_ADD ? sum[WIDTH] : opc == OP_SUB ? dif[WIDTH] : 1'b0;
      flg_nxt[FLAG_OVF] = opc == OP_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
                          opc == OP_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]) :
                          1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) flags <= '0;
    else if (load) flags <= flg_nxt;
  end
`else
  assign flags = '0;
`endif
endmodule
